// File: rtl/hram_fifo_reader.sv
// rtl/hram_fifo_reader.sv - HRAM async FIFO read-side controller with 2-entry skid buffer and burst gapping.
// Optional m_parity output enabled by defining HRAM_FIFO_READER_PARITY_EN.
module hram_fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             out_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fifo_e,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count,
`ifdef HRAM_FIFO_READER_PARITY_EN
    output logic             m_parity,
`endif
    output logic             busy
);

`ifdef HRAM_FIFO_READER_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif
    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       burst_q, burst_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] rd_count_q;
    logic [EW-1:0]    in_ent;
    logic             deq;
    logic [2:0]       fill;

`ifdef HRAM_FIFO_READER_PARITY_EN
    assign in_ent   = {^fifo_data, fifo_data};
    assign m_parity = head_q[WIDTH];
`else
    assign in_ent   = fifo_data;
`endif

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = head_q[WIDTH-1:0];
    assign deq      = m_valid && m_ready;
    assign rd_count = rd_count_q;
    assign busy     = (state_q != IDLE) || inflight_q || (occ_q != 2'd0);

    // Occupancy projected one cycle ahead; a pop now lands in the skid buffer next cycle.
    assign fill     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deq};
    assign fifo_pop = (state_q == ACTIVE) && !fifo_e && en && (fill <= 3'd1);

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (en && !fifo_e) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (fifo_pop) begin
                    if (burst_q + 8'd1 == BURST_LAST) begin
                        state_d = GAP;
                        burst_d = 8'd0;
                    end else begin
                        burst_d = burst_q + 8'd1;
                    end
                end else if (fifo_e || !en) begin
                    state_d = IDLE;
                    burst_d = 8'd0;
                end
            end
            GAP: begin
                state_d = (en && !fifo_e) ? ACTIVE : IDLE;
            end
            default: begin
                state_d = IDLE;
                burst_d = 8'd0;
            end
        endcase
    end

    // Captured word enters behind any held head; simultaneous dequeue shifts first.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({inflight_q, deq})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = in_ent;
                end else begin
                    tail_d = in_ent;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = in_ent;
                end else begin
                    head_d = in_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge out_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            burst_q    <= 8'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_pop;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (deq) begin
                rd_count_q <= rd_count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hram_fifo_reader.sv
// tb/tb_hram_fifo_reader.sv - self-checking bench for hram_fifo_reader against a queue-based FIFO/stream model.
module tb_hram_fifo_reader;

    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 4;

    logic             out_clk = 1'b0;
    logic             reset;
    logic             en;
    logic             fifo_e;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [CNT_W-1:0] rd_count;
    logic             busy;
`ifdef HRAM_FIFO_READER_PARITY_EN
    logic             m_parity;
`endif

    hram_fifo_reader #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
        .out_clk  (out_clk),
        .reset    (reset),
        .en       (en),
        .fifo_e   (fifo_e),
        .fifo_data(fifo_data),
        .fifo_pop (fifo_pop),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .rd_count (rd_count),
`ifdef HRAM_FIFO_READER_PARITY_EN
        .m_parity (m_parity),
`endif
        .busy     (busy)
    );

    always #5 out_clk = ~out_clk;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] ref_q[$];
    int pop_log[$];
    int delivered = 0;
    int pops_seen = 0;
    int run_len = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        ref_q.push_back(w);
        fifo_e = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pop"}, 32'(fifo_pop), 32'd0);
        chk({tag, "_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_data"}, 32'(m_data), 32'd0);
        chk({tag, "_count"}, 32'(rd_count), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef HRAM_FIFO_READER_PARITY_EN
        chk({tag, "_parity"}, 32'(m_parity), 32'd0);
`endif
    endtask

    // One clock: observe at the falling edge, then model the FIFO's read port after the rising edge.
    task automatic cycle();
        logic pop_now;
        @(negedge out_clk);
        chk("rd_count", 32'(rd_count), 32'(delivered % (1 << CNT_W)));
        pop_now = fifo_pop;
        if (pop_now) begin
            chk("pop_while_empty", 32'(fifo_e), 32'd0);
            pops_seen++;
            pop_log.push_back(cyc);
            run_len++;
            chk("burst_run", 32'(run_len <= BURST_LEN), 32'd1);
        end else begin
            run_len = 0;
        end
        if (m_valid) begin
            if (ref_q.size() == 0) begin
                chk("stale_word", 32'(m_valid), 32'd0);
            end else begin
                chk("m_data", 32'(m_data), 32'(ref_q[0]));
`ifdef HRAM_FIFO_READER_PARITY_EN
                chk("m_parity", 32'(m_parity), 32'(^ref_q[0]));
`endif
                if (m_ready) begin
                    void'(ref_q.pop_front());
                    delivered++;
                end
            end
        end
        @(posedge out_clk);
        #1;
        cyc++;
        if (pop_now && fq.size() != 0) fifo_data = fq.pop_front();
        else fifo_data = WIDTH'($urandom);
        fifo_e = (fq.size() == 0);
    endtask

    initial begin
        int n;
        int d0;
        reset = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_e = 1'b1; fifo_data = '0;
        #12;
        chk_zero("reset");
        @(posedge out_clk); #1;
        reset = 1'b0;

        // Stream 0..7 with burst gap
        for (int i = 0; i < 8; i++) push(WIDTH'(i));
        pop_log.delete();
        en = 1'b1; m_ready = 1'b1;
        n = 0;
        while (delivered < 8 && n < 40) begin cycle(); n++; end
        chk("t1_delivered", 32'(delivered), 32'd8);
        chk("t1_pop_count", 32'(pop_log.size()), 32'd8);
        if (pop_log.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk("t1_pop_slot", 32'(pop_log[i] - pop_log[0]), 32'(i < 4 ? i : i + 1));
        end
        cycle();
        chk("t1_rd_count", 32'(rd_count), 32'd8);

        // Backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(WIDTH'(8'h10 + i));
        pops_seen = 0;
        for (int i = 0; i < 6; i++) cycle();
        chk("bp_pops", 32'(pops_seen <= 2), 32'd1);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_head", 32'(m_data), 32'h10);
        m_ready = 1'b1;
        n = 0;
        while (ref_q.size() != 0 && n < 40) begin cycle(); n++; end
        chk("bp_drained", 32'(ref_q.size()), 32'd0);

        // Single word at the empty boundary
        for (int i = 0; i < 4; i++) cycle();
        pops_seen = 0;
        d0 = delivered;
        push(8'hA5);
        n = 0;
        while (delivered == d0 && n < 20) begin cycle(); n++; end
        chk("empty_delivered", 32'(delivered), 32'(d0 + 1));
        cycle();
        chk("empty_pops", 32'(pops_seen), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);

        // Reset while words are buffered and in flight
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(WIDTH'(8'h40 + i));
        for (int i = 0; i < 4; i++) cycle();
        chk("rst_pre_valid", 32'(m_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        fq.delete(); ref_q.delete(); delivered = 0; fifo_e = 1'b1; run_len = 0;
        @(posedge out_clk); @(posedge out_clk); #1;
        reset = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("post_reset_valid", 32'(m_valid), 32'd0);

        // Counter wrap: 17 words with a 4-bit counter
        for (int i = 0; i < 17; i++) push(WIDTH'($urandom));
        n = 0;
        while (ref_q.size() != 0 && n < 80) begin cycle(); n++; end
        chk("wrap_drained", 32'(ref_q.size()), 32'd0);
        cycle();
        chk("wrap_count", 32'(rd_count), 32'd1);

        // Parity-relevant words
        push(8'h03); push(8'h07);
        n = 0;
        while (ref_q.size() != 0 && n < 20) begin cycle(); n++; end
        chk("par_drained", 32'(ref_q.size()), 32'd0);

        // Randomized traffic, enable toggling and backpressure
        for (int i = 0; i < 2000; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            en      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0 && fq.size() < 16) push(WIDTH'($urandom));
            cycle();
        end
        en = 1'b1; m_ready = 1'b1;
        n = 0;
        while (ref_q.size() != 0 && n < 500) begin cycle(); n++; end
        chk("rand_drained", 32'(ref_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        chk("rand_idle_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
